// File: rtl/branch_resolution_unit.sv
// rtl/branch_resolution_unit.sv - in-order branch tag queue with out-of-order resolve and squash
// Entries are indexed by tag; head/tail carry an extra wrap bit that doubles as the tag color.
module branch_resolution_unit #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 32,
    localparam int IDW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic                  alloc_prediction,
    input  logic [ADDR_WIDTH-1:0] alloc_taken_target,
    input  logic [ADDR_WIDTH-1:0] alloc_fallthrough,
    output logic                  alloc_ready,
    output logic [IDW-1:0]        alloc_id,
    output logic                  alloc_color,
    input  logic                  exe_valid,
    input  logic [IDW-1:0]        exe_id,
    input  logic                  exe_color,
    input  logic                  exe_outcome,
    output logic                  result_valid,
    output logic                  result_prediction,
    output logic                  result_outcome,
    output logic [ADDR_WIDTH-1:0] result_recovery_target,
    output logic [IDW-1:0]        result_branch_id,
    output logic                  result_color_bit
);

    localparam logic [IDW:0] PTR_ONE = {{IDW{1'b0}}, 1'b1};

    logic [IDW:0]            head;
    logic [IDW:0]            tail;
    logic [IDW-1:0]          head_idx;
    logic [IDW-1:0]          tail_idx;
    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH-1:0]        ent_resolved;
    logic [DEPTH-1:0]        ent_pred;
    logic [DEPTH-1:0]        ent_outcome;
    logic [DEPTH-1:0]        ent_color;
    logic [ADDR_WIDTH-1:0]   ent_taken [DEPTH];
    logic [ADDR_WIDTH-1:0]   ent_fall  [DEPTH];
    logic                    empty;
    logic                    full;
    logic                    mispredict;
    logic                    exe_accept;
    logic                    alloc_fire;

    assign head_idx = head[IDW-1:0];
    assign tail_idx = tail[IDW-1:0];
    assign empty    = (head == tail);
    assign full     = (head_idx == tail_idx) && (head[IDW] != tail[IDW]);

    assign result_valid           = !empty && ent_valid[head_idx] && ent_resolved[head_idx];
    assign result_prediction      = ent_pred[head_idx];
    assign result_outcome         = ent_outcome[head_idx];
    assign result_recovery_target = ent_outcome[head_idx] ? ent_taken[head_idx] : ent_fall[head_idx];
    assign result_branch_id       = head_idx;
    assign result_color_bit       = ent_color[head_idx];

    assign mispredict  = result_valid && (result_prediction != result_outcome);
    assign alloc_ready = !full && !mispredict;
    assign alloc_id    = tail_idx;
    assign alloc_color = tail[IDW];
    assign alloc_fire  = alloc_valid && alloc_ready;

    // A stale color or already-resolved entry means the report belongs to a squashed or duplicate branch.
    assign exe_accept = exe_valid && !mispredict && ent_valid[exe_id]
                        && (ent_color[exe_id] == exe_color) && !ent_resolved[exe_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            ent_valid    <= '0;
            ent_resolved <= '0;
            ent_pred     <= '0;
            ent_outcome  <= '0;
            ent_color    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_taken[i] <= '0;
                ent_fall[i]  <= '0;
            end
        end else begin
            if (result_valid) begin
                head                <= head + PTR_ONE;
                ent_valid[head_idx] <= 1'b0;
            end
            // Squash: retiring head advances too, so tail = head+1 leaves the queue empty.
            if (mispredict) begin
                tail      <= head + PTR_ONE;
                ent_valid <= '0;
            end else begin
                if (exe_accept) begin
                    ent_resolved[exe_id] <= 1'b1;
                    ent_outcome[exe_id]  <= exe_outcome;
                end
                if (alloc_fire) begin
                    ent_valid[tail_idx]    <= 1'b1;
                    ent_resolved[tail_idx] <= 1'b0;
                    ent_pred[tail_idx]     <= alloc_prediction;
                    ent_outcome[tail_idx]  <= 1'b0;
                    ent_color[tail_idx]    <= tail[IDW];
                    ent_taken[tail_idx]    <= alloc_taken_target;
                    ent_fall[tail_idx]     <= alloc_fallthrough;
                    tail                   <= tail + PTR_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// tb/tb_branch_resolution_unit.sv - directed scenarios plus randomized run against a program-order queue model
module tb_branch_resolution_unit;

    localparam int DEPTH = 8;
    localparam int AW    = 32;
    localparam int IDW   = 3;

    logic           clk;
    logic           rst;
    logic           alloc_valid;
    logic           alloc_prediction;
    logic [AW-1:0]  alloc_taken_target;
    logic [AW-1:0]  alloc_fallthrough;
    logic           alloc_ready;
    logic [IDW-1:0] alloc_id;
    logic           alloc_color;
    logic           exe_valid;
    logic [IDW-1:0] exe_id;
    logic           exe_color;
    logic           exe_outcome;
    logic           result_valid;
    logic           result_prediction;
    logic           result_outcome;
    logic [AW-1:0]  result_recovery_target;
    logic [IDW-1:0] result_branch_id;
    logic           result_color_bit;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            seq;
        logic          pred;
        logic          outcome;
        logic          resolved;
        logic [AW-1:0] tt;
        logic [AW-1:0] ft;
    } br_t;

    br_t mq[$];
    int  next_seq;

    branch_resolution_unit #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .alloc_valid            (alloc_valid),
        .alloc_prediction       (alloc_prediction),
        .alloc_taken_target     (alloc_taken_target),
        .alloc_fallthrough      (alloc_fallthrough),
        .alloc_ready            (alloc_ready),
        .alloc_id               (alloc_id),
        .alloc_color            (alloc_color),
        .exe_valid              (exe_valid),
        .exe_id                 (exe_id),
        .exe_color              (exe_color),
        .exe_outcome            (exe_outcome),
        .result_valid           (result_valid),
        .result_prediction      (result_prediction),
        .result_outcome         (result_outcome),
        .result_recovery_target (result_recovery_target),
        .result_branch_id       (result_branch_id),
        .result_color_bit       (result_color_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic idle_inputs();
        alloc_valid        = 1'b0;
        alloc_prediction   = 1'b0;
        alloc_taken_target = '0;
        alloc_fallthrough  = '0;
        exe_valid          = 1'b0;
        exe_id             = '0;
        exe_color          = 1'b0;
        exe_outcome        = 1'b0;
    endtask

    task automatic set_alloc(input logic p, input logic [AW-1:0] tt, input logic [AW-1:0] ft);
        alloc_valid        = 1'b1;
        alloc_prediction   = p;
        alloc_taken_target = tt;
        alloc_fallthrough  = ft;
    endtask

    task automatic set_exe(input logic [IDW-1:0] id, input logic c, input logic o);
        exe_valid   = 1'b1;
        exe_id      = id;
        exe_color   = c;
        exe_outcome = o;
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid got=%0b exp=0", result_valid); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got=%0b exp=1", alloc_ready); end
        checks++; if (alloc_id !== 3'd0) begin errors++; $display("FAIL reset_alloc_id got=%0d exp=0", alloc_id); end
        checks++; if (alloc_color !== 1'b0) begin errors++; $display("FAIL reset_alloc_color got=%0b exp=0", alloc_color); end
        checks++; if (result_recovery_target !== 32'h0) begin errors++; $display("FAIL reset_target got=%h exp=0", result_recovery_target); end
        checks++; if (result_branch_id !== 3'd0) begin errors++; $display("FAIL reset_branch_id got=%0d exp=0", result_branch_id); end
        end_cycle();
    endtask

    task automatic test_in_order();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(1'b1, AW'((i + 1) * 256), AW'((i + 1) * 256 + 4));
            @(negedge clk);
            checks++; if (alloc_ready !== 1'b1 || alloc_id !== IDW'(i)) begin errors++; $display("FAIL inorder_alloc%0d got ready=%0b id=%0d exp ready=1 id=%0d", i, alloc_ready, alloc_id, i); end
            end_cycle();
        end
        set_exe(3'd0, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL inorder_early got=%0b exp=0", result_valid); end
        end_cycle();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) set_exe(IDW'(i + 1), 1'b0, 1'b1);
            @(negedge clk);
            checks++; if (result_valid !== 1'b1 || result_branch_id !== IDW'(i)) begin errors++; $display("FAIL inorder_result%0d got valid=%0b id=%0d exp valid=1 id=%0d", i, result_valid, result_branch_id, i); end
            checks++; if (result_recovery_target !== AW'((i + 1) * 256)) begin errors++; $display("FAIL inorder_target%0d got=%h exp=%h", i, result_recovery_target, (i + 1) * 256); end
            checks++; if (result_prediction !== 1'b1 || result_outcome !== 1'b1) begin errors++; $display("FAIL inorder_dir%0d got pred=%0b out=%0b exp 1/1", i, result_prediction, result_outcome); end
            end_cycle();
        end
        @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL inorder_drained got=%0b exp=0", result_valid); end
        end_cycle();
    endtask

    task automatic test_out_of_order();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(1'b0, AW'(32'h1000 + i), AW'(32'h2000 + i));
            end_cycle();
        end
        for (int i = 2; i >= 0; i--) begin
            set_exe(IDW'(i), 1'b0, 1'b0);
            @(negedge clk);
            checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL ooo_wait_report%0d got=%0b exp=0", i, result_valid); end
            end_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (result_valid !== 1'b1 || result_branch_id !== IDW'(i)) begin errors++; $display("FAIL ooo_result%0d got valid=%0b id=%0d exp valid=1 id=%0d", i, result_valid, result_branch_id, i); end
            checks++; if (result_recovery_target !== AW'(32'h2000 + i)) begin errors++; $display("FAIL ooo_target%0d got=%h exp=%h", i, result_recovery_target, 32'h2000 + i); end
            end_cycle();
        end
        @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL ooo_drained got=%0b exp=0", result_valid); end
        end_cycle();
    endtask

    task automatic test_mispredict();
        apply_reset();
        set_alloc(1'b0, 32'h400, 32'h00C); end_cycle();
        set_alloc(1'b1, 32'h500, 32'h504); end_cycle();
        set_alloc(1'b1, 32'h600, 32'h604); end_cycle();
        set_exe(3'd0, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mp_before got=%0b exp=0", result_valid); end
        end_cycle();
        set_alloc(1'b1, 32'h700, 32'h704);
        set_exe(3'd1, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (result_valid !== 1'b1 || result_branch_id !== 3'd0) begin errors++; $display("FAIL mp_result got valid=%0b id=%0d exp valid=1 id=0", result_valid, result_branch_id); end
        checks++; if (result_recovery_target !== 32'h400) begin errors++; $display("FAIL mp_target got=%h exp=400", result_recovery_target); end
        checks++; if (result_prediction !== 1'b0 || result_outcome !== 1'b1) begin errors++; $display("FAIL mp_dir got pred=%0b out=%0b exp 0/1", result_prediction, result_outcome); end
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL mp_alloc_blocked got=%0b exp=0", alloc_ready); end
        end_cycle();
        set_exe(3'd1, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mp_empty got=%0b exp=0", result_valid); end
        checks++; if (alloc_ready !== 1'b1 || alloc_id !== 3'd1 || alloc_color !== 1'b0) begin errors++; $display("FAIL mp_next_tag got ready=%0b id=%0d color=%0b exp 1/1/0", alloc_ready, alloc_id, alloc_color); end
        end_cycle();
        @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mp_stale_ignored got=%0b exp=0", result_valid); end
        checks++; if (alloc_id !== 3'd1) begin errors++; $display("FAIL mp_tail_held got=%0d exp=1", alloc_id); end
        end_cycle();
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(1'b1, AW'(32'h1000 + i * 4), AW'(32'h9000 + i * 4));
            @(negedge clk);
            checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL full_fill%0d got ready=%0b exp=1", i, alloc_ready); end
            end_cycle();
        end
        set_alloc(1'b1, 32'hDEAD, 32'hBEEF);
        @(negedge clk);
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b exp=0", alloc_ready); end
        end_cycle();
        set_alloc(1'b1, 32'hDEAD, 32'hBEEF);
        set_exe(3'd0, 1'b0, 1'b1);
        end_cycle();
        set_alloc(1'b1, 32'hDEAD, 32'hBEEF);
        @(negedge clk);
        checks++; if (result_valid !== 1'b1 || result_branch_id !== 3'd0) begin errors++; $display("FAIL full_retire got valid=%0b id=%0d exp 1/0", result_valid, result_branch_id); end
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass got=%0b exp=0", alloc_ready); end
        end_cycle();
        @(negedge clk);
        checks++; if (alloc_ready !== 1'b1 || alloc_id !== 3'd0 || alloc_color !== 1'b1) begin errors++; $display("FAIL full_wrap got ready=%0b id=%0d color=%0b exp 1/0/1", alloc_ready, alloc_id, alloc_color); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL full_head1_pending got=%0b exp=0", result_valid); end
        end_cycle();
    endtask

    task automatic test_stale_color();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(1'b1, AW'(32'h3000 + i * 16), AW'(32'h5000 + i * 16));
            end_cycle();
        end
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) set_exe(IDW'(i), 1'b0, 1'b1);
            @(negedge clk);
            if (i > 0) begin
                checks++; if (result_valid !== 1'b1 || result_branch_id !== IDW'(i - 1)) begin errors++; $display("FAIL stale_drain%0d got valid=%0b id=%0d exp 1/%0d", i - 1, result_valid, result_branch_id, i - 1); end
            end
            end_cycle();
        end
        for (int i = 0; i < 4; i++) begin
            set_alloc(1'b1, AW'(32'h4000 + i * 16), AW'(32'h6000 + i * 16));
            @(negedge clk);
            checks++; if (alloc_id !== IDW'(i) || alloc_color !== 1'b1) begin errors++; $display("FAIL stale_alloc%0d got id=%0d color=%0b exp %0d/1", i, alloc_id, alloc_color, i); end
            end_cycle();
        end
        set_exe(3'd3, 1'b0, 1'b1);
        end_cycle();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_exe(IDW'(i), 1'b1, 1'b1);
            @(negedge clk);
            if (i > 0) begin
                checks++; if (result_valid !== 1'b1 || result_branch_id !== IDW'(i - 1) || result_color_bit !== 1'b1) begin errors++; $display("FAIL stale_c1_result%0d got valid=%0b id=%0d color=%0b exp 1/%0d/1", i - 1, result_valid, result_branch_id, result_color_bit, i - 1); end
            end
            end_cycle();
        end
        set_exe(3'd3, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL stale_ignored got=%0b exp=0", result_valid); end
        end_cycle();
        @(negedge clk);
        checks++; if (result_valid !== 1'b1 || result_branch_id !== 3'd3 || result_color_bit !== 1'b1) begin errors++; $display("FAIL stale_id3 got valid=%0b id=%0d color=%0b exp 1/3/1", result_valid, result_branch_id, result_color_bit); end
        checks++; if (result_recovery_target !== 32'h4030) begin errors++; $display("FAIL stale_id3_target got=%h exp=4030", result_recovery_target); end
        end_cycle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_alloc(1'b1, 32'h111, 32'h222); end_cycle();
        set_alloc(1'b1, 32'h333, 32'h444); end_cycle();
        set_exe(3'd0, 1'b0, 1'b1); end_cycle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (result_valid !== 1'b0 || alloc_ready !== 1'b1 || alloc_id !== 3'd0) begin errors++; $display("FAIL midreset_state got valid=%0b ready=%0b id=%0d exp 0/1/0", result_valid, alloc_ready, alloc_id); end
        end_cycle();
        set_exe(3'd1, 1'b0, 1'b1);
        end_cycle();
        @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL midreset_discarded got=%0b exp=0", result_valid); end
        end_cycle();
    endtask

    task automatic test_random();
        logic          exp_rv;
        logic          exp_mp;
        logic          exp_ar;
        int            hs;
        int            k;
        apply_reset();
        mq.delete();
        next_seq = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst                = ($urandom_range(0, 199) == 0);
            alloc_valid        = ($urandom_range(0, 9) < 6);
            alloc_prediction   = 1'($urandom_range(0, 1));
            alloc_taken_target = $urandom;
            alloc_fallthrough  = $urandom;
            exe_valid          = ($urandom_range(0, 9) < 6);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                k           = int'($urandom_range(0, mq.size() - 1));
                exe_id      = IDW'(mq[k].seq % DEPTH);
                exe_color   = 1'((mq[k].seq / DEPTH) % 2);
                exe_outcome = ($urandom_range(0, 9) < 8) ? mq[k].pred : !mq[k].pred;
            end else begin
                exe_id      = IDW'($urandom_range(0, DEPTH - 1));
                exe_color   = 1'($urandom_range(0, 1));
                exe_outcome = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            exp_rv = (mq.size() > 0) && mq[0].resolved;
            exp_mp = exp_rv && (mq[0].pred != mq[0].outcome);
            exp_ar = (mq.size() < DEPTH) && !exp_mp;
            checks++; if (result_valid !== exp_rv) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, result_valid, exp_rv); end
            if (exp_rv) begin
                checks++; if (result_branch_id !== IDW'(mq[0].seq % DEPTH) || result_color_bit !== 1'((mq[0].seq / DEPTH) % 2)) begin errors++; $display("FAIL rnd_tag cyc=%0d got id=%0d color=%0b exp id=%0d color=%0d", cyc, result_branch_id, result_color_bit, mq[0].seq % DEPTH, (mq[0].seq / DEPTH) % 2); end
                checks++; if (result_prediction !== mq[0].pred || result_outcome !== mq[0].outcome) begin errors++; $display("FAIL rnd_dir cyc=%0d got pred=%0b out=%0b exp pred=%0b out=%0b", cyc, result_prediction, result_outcome, mq[0].pred, mq[0].outcome); end
                checks++; if (result_recovery_target !== (mq[0].outcome ? mq[0].tt : mq[0].ft)) begin errors++; $display("FAIL rnd_target cyc=%0d got=%h exp=%h", cyc, result_recovery_target, mq[0].outcome ? mq[0].tt : mq[0].ft); end
            end
            checks++; if (alloc_ready !== exp_ar) begin errors++; $display("FAIL rnd_alloc_ready cyc=%0d got=%0b exp=%0b", cyc, alloc_ready, exp_ar); end
            checks++; if (alloc_id !== IDW'(next_seq % DEPTH) || alloc_color !== 1'((next_seq / DEPTH) % 2)) begin errors++; $display("FAIL rnd_alloc_tag cyc=%0d got id=%0d color=%0b exp id=%0d color=%0d", cyc, alloc_id, alloc_color, next_seq % DEPTH, (next_seq / DEPTH) % 2); end
            if (rst) begin
                mq.delete();
                next_seq = 0;
            end else begin
                hs = 0;
                if (exp_rv) begin
                    hs = mq[0].seq;
                    void'(mq.pop_front());
                end
                if (exp_mp) begin
                    mq.delete();
                    next_seq = hs + 1;
                end else begin
                    if (exe_valid) begin
                        for (int i = 0; i < mq.size(); i++) begin
                            if ((mq[i].seq % DEPTH) == int'(exe_id) && ((mq[i].seq / DEPTH) % 2) == int'(exe_color) && !mq[i].resolved) begin
                                mq[i].resolved = 1'b1;
                                mq[i].outcome  = exe_outcome;
                            end
                        end
                    end
                    if (alloc_valid && exp_ar) begin
                        mq.push_back('{seq: next_seq, pred: alloc_prediction, outcome: 1'b0, resolved: 1'b0, tt: alloc_taken_target, ft: alloc_fallthrough});
                        next_seq++;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_in_order();
        test_out_of_order();
        test_mispredict();
        test_full_wrap();
        test_stale_color();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
